// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - default 640x480@60 raster constants and total derivation
package vga_timing_pkg;

    localparam int CNT_W = 10;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;

    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;

    function automatic int span_total(input int active, input int fp, input int sync_w, input int bp);
        return active + fp + sync_w + bp;
    endfunction

endpackage

// File: rtl/vga_lock_sync.sv
// rtl/vga_lock_sync.sv - two-flop synchronizer for the PLL lock indication
module vga_lock_sync (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic sync_out
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = async_in;
        sync_d = meta_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign sync_out = sync_q;

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster timing generator with registered outputs
// VGA_TIMING_LOCK_GATE_EN gates counting on the synchronized PLL lock.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF,
    parameter int SYNC_POL = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pll_locked,
    output logic       hsync,
    output logic       vsync,
    output logic       de,
    output logic [9:0] px_x,
    output logic [9:0] px_y,
    output logic       sof,
    output logic       eol
);

    localparam int H_TOTAL = span_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = span_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT_C  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT_C  = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] H_EOL    = CNT_W'(H_ACTIVE - 1);
    localparam logic [CNT_W-1:0] HS_BEG   = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CNT_W-1:0] VS_BEG   = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic             SYNC_ON  = (SYNC_POL != 0);

    logic run;

`ifdef VGA_TIMING_LOCK_GATE_EN
    vga_lock_sync u_lock_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (pll_locked),
        .sync_out (run)
    );
`else
    logic unused_pll_locked;
    assign unused_pll_locked = pll_locked;
    assign run = 1'b1;
`endif

    logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
    logic [CNT_W-1:0] v_cnt_q, v_cnt_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             de_q, de_d;
    logic [9:0]       px_x_q, px_x_d;
    logic [9:0]       px_y_q, px_y_d;
    logic             sof_q, sof_d;
    logic             eol_q, eol_d;
    logic             active;

    always_comb begin
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        if (rst || !run) begin
            h_cnt_d = '0;
            v_cnt_d = '0;
        end else if (h_cnt_q == H_LAST) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
        end else begin
            h_cnt_d = h_cnt_q + 1'b1;
        end
    end

    // Outputs decode the counters before they advance, giving one cycle of latency.
    always_comb begin
        active  = (h_cnt_q < H_ACT_C) && (v_cnt_q < V_ACT_C);
        hsync_d = !SYNC_ON;
        vsync_d = !SYNC_ON;
        de_d    = 1'b0;
        px_x_d  = '0;
        px_y_d  = '0;
        sof_d   = 1'b0;
        eol_d   = 1'b0;
        if (!rst && run) begin
            de_d    = active;
            px_x_d  = active ? h_cnt_q : '0;
            px_y_d  = active ? v_cnt_q : '0;
            hsync_d = (h_cnt_q >= HS_BEG && h_cnt_q <= HS_END) ? SYNC_ON : !SYNC_ON;
            vsync_d = (v_cnt_q >= VS_BEG && v_cnt_q <= VS_END) ? SYNC_ON : !SYNC_ON;
            sof_d   = active && (h_cnt_q == '0) && (v_cnt_q == '0);
            eol_d   = active && (h_cnt_q == H_EOL);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
            hsync_q <= !SYNC_ON;
            vsync_q <= !SYNC_ON;
            de_q    <= 1'b0;
            px_x_q  <= '0;
            px_y_q  <= '0;
            sof_q   <= 1'b0;
            eol_q   <= 1'b0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            de_q    <= de_d;
            px_x_q  <= px_x_d;
            px_y_q  <= px_y_d;
            sof_q   <= sof_d;
            eol_q   <= eol_d;
        end
    end

    assign hsync = hsync_q;
    assign vsync = vsync_q;
    assign de    = de_q;
    assign px_x  = px_x_q;
    assign px_y  = px_y_q;
    assign sof   = sof_q;
    assign eol   = eol_q;

endmodule
